cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) / ROB writeback port between NUM_REQ functional units (ALU, MUL, DIV, LSU).
- Each unit presents a completed result tagged with its ROB index.
- The arbiter grants one unit per cycle and registers the winner onto the CDB, where the ROB and reservation stations consume it.
- Provides valid/ready backpressure toward the units, honours downstream backpressure from the ROB, and drops in-flight state on pipeline flush.

---
 rtl/cdb_arbiter_if.sv | 35 +++
 rtl/cdb_arbiter.sv | 83 ++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: functional-unit result requests on one side and the
// registered common-data-bus broadcast on the other.
`timescale 1ns/1ps
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ROB_DEPTH = 3,
  parameter int unsigned DATA_W    = 32
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ROB_DEPTH-1:0] req_rob;
  logic [NUM_REQ*5-1:0]         req_rd_s;
  logic [NUM_REQ*DATA_W-1:0]    req_rd_v;

  logic                         cdb_valid;
  logic                         cdb_ready;
  logic [ROB_DEPTH-1:0]         cdb_rob;
  logic [4:0]                   cdb_rd_s;
  logic [DATA_W-1:0]            cdb_rd_v;
  logic [SRC_W-1:0]             cdb_src;

  // Units and ROB side: present results, consume the broadcast.
  modport master (
    output req_valid, req_rob, req_rd_s, req_rd_v, cdb_ready,
    input  req_ready, cdb_valid, cdb_rob, cdb_rd_s, cdb_rd_v, cdb_src
  );

  // Arbiter side: grants one unit and drives the broadcast register.
  modport slave (
    input  req_valid, req_rob, req_rd_s, req_rd_v, cdb_ready,
    output req_ready, cdb_valid, cdb_rob, cdb_rd_s, cdb_rd_v, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB / ROB writeback port between
// NUM_REQ functional units. One grant per cycle, winner registered onto the
// CDB; honours ROB backpressure and drops the broadcast on flush.
`timescale 1ns/1ps
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ROB_DEPTH = 3,
  parameter int unsigned DATA_W    = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned    SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SRC_W:0] NUM_REQ_W  = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  logic [ROB_DEPTH-1:0] rob_a  [NUM_REQ];
  logic [4:0]           rd_s_a [NUM_REQ];
  logic [DATA_W-1:0]    rd_v_a [NUM_REQ];

  logic [SRC_W-1:0]     ptr;
  logic [SRC_W-1:0]     winner;
  logic [SRC_W:0]       idx;
  logic                 any_valid;
  logic                 grant_en;
  logic                 transfer;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rob_a[g]  = bus.req_rob[g*ROB_DEPTH +: ROB_DEPTH];
    assign rd_s_a[g] = bus.req_rd_s[g*5 +: 5];
    assign rd_v_a[g] = bus.req_rd_v[g*DATA_W +: DATA_W];
  end

  // Output register may load when empty or being drained; never during flush or reset.
  assign grant_en = (~bus.cdb_valid | bus.cdb_ready) & ~flush & rst;
  assign transfer = grant_en & any_valid;

  // Rotating-priority search: first valid unit at or after ptr, wrapping.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (SRC_W+1)'(i);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (!any_valid && bus.req_valid[idx[SRC_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[SRC_W-1:0];
      end
    end
  end

  // One-hot grant to the winner only when the output register can take it.
  always_comb begin
    bus.req_ready = '0;
    if (transfer) bus.req_ready[winner] = 1'b1;
  end

  // CDB register and pointer: flush beats transfer, transfer beats drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_rob   <= '0;
      bus.cdb_rd_s  <= '0;
      bus.cdb_rd_v  <= '0;
      bus.cdb_src   <= '0;
      ptr           <= '0;
    end else if (flush) begin
      bus.cdb_valid <= 1'b0;
    end else if (transfer) begin
      bus.cdb_valid <= 1'b1;
      bus.cdb_rob   <= rob_a[winner];
      bus.cdb_rd_s  <= rd_s_a[winner];
      bus.cdb_rd_v  <= rd_v_a[winner];
      bus.cdb_src   <= winner;
      ptr           <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end else if (bus.cdb_ready) begin
      bus.cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference pointer model plus a
// scoreboard of expected broadcasts, with directed scenarios on top.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned RD = 3;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(NR), .ROB_DEPTH(RD), .DATA_W(DW)) bus ();

  cdb_arbiter #(.NUM_REQ(NR), .ROB_DEPTH(RD), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [RD-1:0] t_rob [NR];
  logic [4:0]    t_rds [NR];
  logic [DW-1:0] t_rdv [NR];

  logic [1:0]  m_ptr   = 2'd0;
  logic        m_valid = 1'b0;
  logic [41:0] sb [$];
  logic [3:0]  g;

  // Sources keep request and payload stable until granted (flush releases them).
  for (genvar i = 0; i < NR; i++) begin : g_src_rule
    assert property (@(posedge clk) disable iff (!rst)
      (bus.req_valid[i] && !bus.req_ready[i] && !flush) |=>
        (flush || (bus.req_valid[i] && $stable(bus.req_rob[i*RD +: RD]) &&
                   $stable(bus.req_rd_s[i*5 +: 5]) && $stable(bus.req_rd_v[i*DW +: DW]))))
      else $error("source rule broken on unit %0d", i);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_unit(input int u, input logic [RD-1:0] rob, input logic [4:0] rds,
                          input logic [DW-1:0] rdv);
    t_rob[u] = rob;
    t_rds[u] = rds;
    t_rdv[u] = rdv;
    bus.req_rob  = {t_rob[3], t_rob[2], t_rob[1], t_rob[0]};
    bus.req_rd_s = {t_rds[3], t_rds[2], t_rds[1], t_rds[0]};
    bus.req_rd_v = {t_rdv[3], t_rdv[2], t_rdv[1], t_rdv[0]};
  endtask

  // One cycle: check grant and broadcast mid-cycle, advance model, step past the edge.
  task automatic step(output logic [3:0] gnt);
    logic       le;
    logic       found;
    logic [1:0] w;
    logic [1:0] c;
    logic [3:0] eg;
    @(negedge clk);
    gnt   = bus.req_ready;
    le    = (!m_valid || bus.cdb_ready) && !flush;
    found = 1'b0;
    w     = 2'd0;
    for (int k = 0; k < NR; k++) begin
      c = m_ptr + 2'(k);
      if (!found && bus.req_valid[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    eg = (le && found) ? (4'd1 << w) : 4'd0;
    chk("req_ready", 64'(gnt), 64'(eg));
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    if (m_valid && sb.size() > 0)
      chk("payload", 64'({bus.cdb_src, bus.cdb_rob, bus.cdb_rd_s, bus.cdb_rd_v}), 64'(sb[0]));
    if (flush) begin
      m_valid = 1'b0;
      sb.delete();
    end else if (le && found) begin
      if (m_valid && sb.size() > 0) void'(sb.pop_front());
      sb.push_back({w, t_rob[w], t_rds[w], t_rdv[w]});
      m_valid = 1'b1;
      m_ptr   = w + 2'd1;
    end else if (bus.cdb_ready) begin
      if (m_valid && sb.size() > 0) void'(sb.pop_front());
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.cdb_ready = 1'b0;
    for (int u = 0; u < NR; u++)
      set_unit(u, 3'(u + 1), 5'(u + 10), 32'hA000_0000 + 32'(u));

    // Reset: no grants even with every unit requesting.
    bus.req_valid = 4'hF;
    bus.cdb_ready = 1'b1;
    #3;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_src",   64'(bus.cdb_src),   64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(bus.cdb_valid), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Rotation from a fresh pointer.
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step(g);
      chk("rot_grant", 64'(g), 64'(4'd1 << (k % 4)));
      chk("rot_src", 64'(bus.cdb_src), 64'(k % 4));
    end
    flush = 1'b1;
    step(g);
    chk("rot_flush_grant", 64'(g), 64'd0);
    chk("rot_flush_valid", 64'(bus.cdb_valid), 64'd0);
    flush = 1'b0;
    bus.req_valid = '0;

    // Single request with a specific payload.
    set_unit(2, 3'd5, 5'd7, 32'hDEAD_BEEF);
    bus.req_valid = 4'b0100;
    step(g);
    chk("t1_grant", 64'(g), 64'b0100);
    bus.req_valid = '0;
    chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
    chk("t1_rob",   64'(bus.cdb_rob),   64'd5);
    chk("t1_rds",   64'(bus.cdb_rd_s),  64'd7);
    chk("t1_rdv",   64'(bus.cdb_rd_v),  64'hDEAD_BEEF);
    chk("t1_src",   64'(bus.cdb_src),   64'd2);
    step(g);
    chk("t1_drain", 64'(bus.cdb_valid), 64'd0);

    // Backpressure: hold for three cycles, then resume with no bubble.
    bus.req_valid = 4'b0011;
    step(g);
    chk("bp_first", 64'(g), 64'b0001);
    bus.cdb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(g);
      chk("bp_grant", 64'(g), 64'd0);
      chk("bp_src",   64'(bus.cdb_src),  64'd0);
      chk("bp_rdv",   64'(bus.cdb_rd_v), 64'hA000_0000);
    end
    bus.cdb_ready = 1'b1;
    step(g);
    chk("bp_resume", 64'(g), 64'b0010);
    chk("bp_nobubble_valid", 64'(bus.cdb_valid), 64'd1);
    chk("bp_nobubble_src",   64'(bus.cdb_src),   64'd1);

    // Flush with a live broadcast and ROB ready: cleared, no grant.
    bus.req_valid = 4'b0010;
    flush = 1'b1;
    step(g);
    chk("fl_grant", 64'(g), 64'd0);
    chk("fl_valid", 64'(bus.cdb_valid), 64'd0);
    flush = 1'b0;
    step(g);
    chk("fl_regrant", 64'(g), 64'b0010);
    chk("fl_src", 64'(bus.cdb_src), 64'd1);
    bus.req_valid = '0;
    step(g);

    // Fairness between units 0 and 3 (pointer now at 2, so unit 3 leads).
    bus.req_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      step(g);
      chk("fair", 64'(g), (k % 2 == 0) ? 64'b1000 : 64'b0001);
    end
    flush = 1'b1;
    step(g);
    flush = 1'b0;
    bus.req_valid = '0;

    // Asynchronous reset between edges while the CDB is busy.
    bus.req_valid = 4'b0100;
    step(g);
    chk("ar_grant", 64'(g), 64'b0100);
    bus.req_valid = '0;
    bus.cdb_ready = 1'b0;
    chk("ar_pre_src", 64'(bus.cdb_src), 64'd2);
    #2;
    rst = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    chk("ar_valid", 64'(bus.cdb_valid), 64'd0);
    chk("ar_src",   64'(bus.cdb_src),   64'd0);
    chk("ar_rob",   64'(bus.cdb_rob),   64'd0);
    chk("ar_ready", 64'(bus.req_ready), 64'd0);
    m_valid = 1'b0;
    m_ptr   = 2'd0;
    sb.delete();
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.cdb_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    step(g);
    chk("ar_first", 64'(g), 64'b0001);
    step(g);
    chk("ar_second", 64'(g), 64'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
